// File: rtl/signed_mult_seq.sv
// Multi-cycle signed multiplier: magnitude, unsigned shift-add, then re-sign the product.
// Optional macro SEQ_MULT_EARLY_TERM_EN leaves MUL as soon as the remaining multiplier bits are zero.
module signed_mult_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  // state  | meaning
  // S_IDLE | waiting for start; done pulses here for one cycle after S_SIGN
  // S_ABS  | convert latched operands to magnitudes, clear accumulator
  // S_MUL  | one shift-add step per cycle
  // S_SIGN | apply recorded sign to the accumulator, publish product
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ABS  = 2'd1,
    S_MUL  = 2'd2,
    S_SIGN = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0]   ONE_W    = 1;
  localparam logic [2*WIDTH-1:0] ONE_2W   = 1;
  localparam logic [CNT_W-1:0]   CNT_ONE  = 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     mag_a_q, mag_a_d;
  logic [WIDTH-1:0]     mag_b_q, mag_b_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 neg_q, neg_d;
  logic                 done_q, done_d;
  logic [2*WIDTH-1:0]   addend;

  assign addend = {{WIDTH{1'b0}}, mag_a_q} << cnt_q;

  always_comb begin
    state_d   = state_q;
    mag_a_d   = mag_a_q;
    mag_b_d   = mag_b_q;
    acc_d     = acc_q;
    product_d = product_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mag_a_d = a;
          mag_b_d = b;
          neg_d   = a[WIDTH-1] ^ b[WIDTH-1];
          state_d = S_ABS;
        end
      end
      S_ABS: begin
        // The most negative value negates to itself, which reads correctly as unsigned.
        mag_a_d = mag_a_q[WIDTH-1] ? (~mag_a_q + ONE_W) : mag_a_q;
        mag_b_d = mag_b_q[WIDTH-1] ? (~mag_b_q + ONE_W) : mag_b_q;
        acc_d   = '0;
        cnt_d   = '0;
        state_d = S_MUL;
`ifdef SEQ_MULT_EARLY_TERM_EN
        if (mag_b_d == '0) state_d = S_SIGN;
`endif
      end
      S_MUL: begin
        if (mag_b_q[0]) acc_d = acc_q + addend;
        mag_b_d = mag_b_q >> 1;
        cnt_d   = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) state_d = S_SIGN;
`ifdef SEQ_MULT_EARLY_TERM_EN
        if (mag_b_d == '0) state_d = S_SIGN;
`endif
      end
      S_SIGN: begin
        // Negating zero in full width yields zero, so no special case is needed.
        product_d = neg_q ? (~acc_q + ONE_2W) : acc_q;
        done_d    = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mag_a_q   <= '0;
      mag_b_q   <= '0;
      acc_q     <= '0;
      product_q <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mag_a_q   <= mag_a_d;
      mag_b_q   <= mag_b_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      done_q    <= done_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_signed_mult_seq.sv
// Directed bench for signed_mult_seq: products, latency, handshake and mid-op reset.
module tb_signed_mult_seq;
  localparam int W = 32;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [W-1:0]    a;
  logic [W-1:0]    b;
  logic            busy;
  logic            done;
  logic [2*W-1:0]  product;

  int vectors;
  int miscompares;
  int lat;
  int busy_n;
  int extra;

  signed_mult_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Expected start-to-done clocks for a given multiplier.
  function automatic int exp_lat(input logic [W-1:0] mb);
`ifdef SEQ_MULT_EARLY_TERM_EN
    logic [W-1:0] m;
    m = mb[W-1] ? (~mb + 32'd1) : mb;
    if (m == '0) return 2;
    for (int i = W - 1; i >= 0; i--) begin
      if (m[i]) return 3 + i;
    end
    return 2;
`else
    return W + 2;
`endif
  endfunction

  // Called at a negedge: start is sampled at the next posedge; returns at the following negedge.
  task automatic start_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b);
    a = op_a;
    b = op_b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  task automatic wait_done(output int l, output int bn);
    l  = 0;
    bn = (busy === 1'b1) ? 1 : 0;
    while (done !== 1'b1 && l < 200) begin
      @(negedge clk);
      l++;
      if (busy === 1'b1) bn++;
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                        input logic [63:0] exp_p);
    start_op(op_a, op_b);
    wait_done(lat, busy_n);
    chk({tag, "_product"}, product, exp_p);
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat(op_b)));
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    #3;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_product", product, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    start_op(32'd7, 32'd6);
    wait_done(lat, busy_n);
    chk("pos_pos_product", product, 64'd42);
    chk("pos_pos_latency", 64'(lat), 64'(exp_lat(32'd6)));
    chk("pos_pos_busy_cycles", 64'(busy_n), 64'(exp_lat(32'd6)));
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("product_held", product, 64'd42);

    run_op("neg_pos", 32'hFFFF_FFFB, 32'd3, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op("pos_neg", 32'd3, 32'hFFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op("min_min", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    run_op("min_one", 32'h8000_0000, 32'd1, 64'hFFFF_FFFF_8000_0000);
    run_op("zero_neg", 32'd0, 32'hFFFF_FFF7, 64'd0);
    run_op("negb_zero", 32'hFFFF_FFF7, 32'd0, 64'd0);

    // Start re-pulsed ten cycles into an operation must be ignored.
    start_op(32'd3, 32'h7FFF_FFFF);
    repeat (9) @(negedge clk);
    a = 32'd100;
    b = 32'd100;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, busy_n);
    chk("repulse_product", product, 64'h0000_0001_7FFF_FFFD);
    chk("repulse_latency", 64'(lat + 10), 64'(exp_lat(32'h7FFF_FFFF)));
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    chk("repulse_single_done", 64'(extra), 64'd0);
    chk("repulse_idle_busy", 64'(busy), 64'd0);

    // Back-to-back: second start lands in the done cycle of the first.
    run_op("b2b_first", 32'd5, 32'hFFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFDD);
    run_op("b2b_second", 32'd2, 32'd2, 64'd4);

    // Asynchronous reset mid-operation.
    start_op(32'd11, 32'd13);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_product", product, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("after_rst", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
